// File: rtl/onehot_event_server_pkg.sv
// Shared helpers for the one-hot event server: width computation used to size
// the binary index port.
package onehot_event_server_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_event_server_priority.sv
// Fixed-priority one-hot pick: isolates the lowest (or highest) set bit of elig.
module onehot_priority #(
  parameter int W_INPUT      = 8,
  parameter int HIGHEST_WINS = 0
) (
  input  logic [W_INPUT-1:0] elig,
  output logic [W_INPUT-1:0] sel
);

  // The last match scanned overwrites earlier ones, so scan toward the winner.
  always_comb begin
    sel = '0;
    if (HIGHEST_WINS != 0) begin
      for (int i = 0; i < W_INPUT; i++) begin
        if (elig[i]) begin
          sel = W_INPUT'(1) << i;
        end
      end
    end else begin
      for (int i = W_INPUT - 1; i >= 0; i--) begin
        if (elig[i]) begin
          sel = W_INPUT'(1) << i;
        end
      end
    end
  end

endmodule

// File: rtl/onehot_event_server.sv
// Sticky event collector that serves pending, unmasked lines one at a time as
// a binary index on a registered valid/ready output stage.
module onehot_event_server
  import onehot_event_server_pkg::*;
#(
  parameter int  W_INPUT      = 8,
  parameter int  HIGHEST_WINS = 0,
  localparam int W_INDEX      = (W_INPUT > 1) ? clog2(W_INPUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_INPUT-1:0] in_pulse,
  input  logic [W_INPUT-1:0] mask,
  output logic [W_INPUT-1:0] pending,
  output logic [W_INPUT-1:0] dropped,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_INDEX-1:0] out_index,
  output logic [W_INPUT-1:0] out_onehot
);

  logic [W_INPUT-1:0] pending_q, pending_d;
  logic [W_INPUT-1:0] dropped_q, dropped_d;
  logic [W_INPUT-1:0] out_onehot_q, out_onehot_d;
  logic [W_INDEX-1:0] out_index_q, out_index_d;
  logic               out_valid_q, out_valid_d;

  logic [W_INPUT-1:0] elig;
  logic [W_INPUT-1:0] sel;
  logic [W_INPUT-1:0] take;
  logic [W_INDEX-1:0] sel_index;
  logic               load;

  assign elig = pending_q & mask;

  onehot_priority #(
    .W_INPUT      (W_INPUT),
    .HIGHEST_WINS (HIGHEST_WINS)
  ) u_priority (
    .elig (elig),
    .sel  (sel)
  );

  // sel has at most one bit set, so OR-ing the indices of set bits is an exact encode.
  always_comb begin
    sel_index = '0;
    for (int i = 0; i < W_INPUT; i++) begin
      if (sel[i]) begin
        sel_index = sel_index | W_INDEX'(i);
      end
    end
  end

  always_comb begin
    load         = (|elig) && (!out_valid_q || out_ready);
    take         = load ? sel : '0;
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    out_index_d  = out_index_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_onehot_d = sel;
      out_index_d  = sel_index;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_onehot_d = '0;
    end
    // A pulse on the line being taken re-arms it rather than counting as a drop.
    pending_d = (pending_q & ~take) | in_pulse;
    dropped_d = in_pulse & pending_q & ~take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      dropped_q    <= '0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_index_q  <= '0;
    end else begin
      pending_q    <= pending_d;
      dropped_q    <= dropped_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_index_q  <= out_index_d;
    end
  end

  assign pending    = pending_q;
  assign dropped    = dropped_q;
  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_index  = out_index_q;

endmodule

// File: tb/tb_onehot_event_server.sv
// Scoreboard bench: stimulus pushes expected indices, negedge monitors pop and
// compare on every handshake, for a lowest-wins and a highest-wins instance.
module tb_onehot_event_server;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_pulse;
  logic [7:0] in_pulse_h;
  logic [7:0] mask;
  logic       out_ready;

  logic [7:0] pending_l, dropped_l, out_onehot_l;
  logic [2:0] out_index_l;
  logic       out_valid_l;
  logic [7:0] pending_h, dropped_h, out_onehot_h;
  logic [2:0] out_index_h;
  logic       out_valid_h;

  int checks = 0;
  int errors = 0;
  int exp_lo[$];
  int exp_hi[$];

  always #5 clk = ~clk;

  onehot_event_server #(.W_INPUT(8), .HIGHEST_WINS(0)) dut_lo (
    .clk        (clk),
    .rst        (rst),
    .in_pulse   (in_pulse),
    .mask       (mask),
    .pending    (pending_l),
    .dropped    (dropped_l),
    .out_valid  (out_valid_l),
    .out_ready  (out_ready),
    .out_index  (out_index_l),
    .out_onehot (out_onehot_l)
  );

  onehot_event_server #(.W_INPUT(8), .HIGHEST_WINS(1)) dut_hi (
    .clk        (clk),
    .rst        (rst),
    .in_pulse   (in_pulse_h),
    .mask       (8'hff),
    .pending    (pending_h),
    .dropped    (dropped_h),
    .out_valid  (out_valid_h),
    .out_ready  (1'b1),
    .out_index  (out_index_h),
    .out_onehot (out_onehot_h)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Holds the pulse vectors across exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi);
    sync();
    in_pulse   = lo;
    in_pulse_h = hi;
    sync();
    in_pulse   = '0;
    in_pulse_h = '0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_l && out_ready) begin
      if (exp_lo.size() == 0) begin
        checkOutput("lo_unexpected_output", {29'd0, out_index_l}, 32'hffff_ffff);
      end else begin
        int e;
        e = exp_lo.pop_front();
        checkOutput("lo_out_index", {29'd0, out_index_l}, 32'(e));
        checkOutput("lo_out_onehot", {24'd0, out_onehot_l}, 32'(1) << e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_h) begin
      if (exp_hi.size() == 0) begin
        checkOutput("hi_unexpected_output", {29'd0, out_index_h}, 32'hffff_ffff);
      end else begin
        int e;
        e = exp_hi.pop_front();
        checkOutput("hi_out_index", {29'd0, out_index_h}, 32'(e));
        checkOutput("hi_out_onehot", {24'd0, out_onehot_h}, 32'(1) << e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_pulse   = '0;
    in_pulse_h = '0;
    mask       = 8'hff;
    out_ready  = 1'b1;
    waitCycles(2);
    checkOutput("reset_pending", {24'd0, pending_l}, 32'h0);
    checkOutput("reset_dropped", {24'd0, dropped_l}, 32'h0);
    checkOutput("reset_out_valid", {31'd0, out_valid_l}, 32'h0);
    checkOutput("reset_out_onehot", {24'd0, out_onehot_l}, 32'h0);
    checkOutput("reset_out_index", {29'd0, out_index_l}, 32'h0);
    sync();
    rst = 1'b0;

    $display("[TB] basic ordering, lowest wins");
    exp_lo.push_back(2);
    exp_lo.push_back(3);
    exp_lo.push_back(5);
    applyStimulus(8'b0010_1100, 8'h00);
    @(negedge clk);
    checkOutput("s1_valid_after_1", {31'd0, out_valid_l}, 32'h0);
    checkOutput("s1_pending_set", {24'd0, pending_l}, 32'h2c);
    @(negedge clk);
    checkOutput("s1_valid_after_2", {31'd0, out_valid_l}, 32'h1);
    waitCycles(5);
    checkOutput("s1_queue_drained", 32'(exp_lo.size()), 32'h0);
    checkOutput("s1_pending_end", {24'd0, pending_l}, 32'h0);
    checkOutput("s1_dropped_end", {24'd0, dropped_l}, 32'h0);
    checkOutput("s1_valid_end", {31'd0, out_valid_l}, 32'h0);

    $display("[TB] highest wins");
    exp_hi.push_back(5);
    exp_hi.push_back(3);
    exp_hi.push_back(2);
    applyStimulus(8'h00, 8'b0010_1100);
    waitCycles(6);
    checkOutput("s2_queue_drained", 32'(exp_hi.size()), 32'h0);
    checkOutput("s2_pending_end", {24'd0, pending_h}, 32'h0);
    checkOutput("s2_dropped_end", {24'd0, dropped_h}, 32'h0);

    $display("[TB] backpressure stability");
    sync();
    out_ready = 1'b0;
    applyStimulus(8'b0100_0010, 8'h00);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) in_pulse = 8'h01;
      if (i == 4) in_pulse = 8'h00;
      checkOutput("s3_hold_valid", {31'd0, out_valid_l}, 32'h1);
      checkOutput("s3_hold_index", {29'd0, out_index_l}, 32'h1);
      checkOutput("s3_hold_onehot", {24'd0, out_onehot_l}, 32'h02);
    end
    checkOutput("s3_pending_held", {24'd0, pending_l}, 32'h41);
    checkOutput("s3_dropped", {24'd0, dropped_l}, 32'h0);
    exp_lo.push_back(1);
    exp_lo.push_back(0);
    exp_lo.push_back(6);
    sync();
    out_ready = 1'b1;
    waitCycles(5);
    checkOutput("s3_queue_drained", 32'(exp_lo.size()), 32'h0);
    checkOutput("s3_pending_end", {24'd0, pending_l}, 32'h0);

    $display("[TB] drop and set-wins");
    sync();
    mask = 8'hef;
    applyStimulus(8'h10, 8'h00);
    @(negedge clk);
    checkOutput("s4_pending_first", {24'd0, pending_l}, 32'h10);
    checkOutput("s4_no_drop_first", {24'd0, dropped_l}, 32'h0);
    applyStimulus(8'h10, 8'h00);
    @(negedge clk);
    checkOutput("s4_drop_pulse", {24'd0, dropped_l}, 32'h10);
    @(negedge clk);
    checkOutput("s4_drop_clear", {24'd0, dropped_l}, 32'h0);
    checkOutput("s4_masked_no_valid", {31'd0, out_valid_l}, 32'h0);
    exp_lo.push_back(4);
    exp_lo.push_back(4);
    sync();
    mask     = 8'hff;
    in_pulse = 8'h10;
    sync();
    in_pulse = 8'h00;
    @(negedge clk);
    checkOutput("s4_setwins_pending", {24'd0, pending_l}, 32'h10);
    checkOutput("s4_setwins_no_drop", {24'd0, dropped_l}, 32'h0);
    waitCycles(4);
    checkOutput("s4_queue_drained", 32'(exp_lo.size()), 32'h0);
    checkOutput("s4_pending_end", {24'd0, pending_l}, 32'h0);

    $display("[TB] masking");
    sync();
    mask = 8'h0f;
    applyStimulus(8'hf0, 8'h00);
    waitCycles(3);
    checkOutput("s5_masked_valid", {31'd0, out_valid_l}, 32'h0);
    checkOutput("s5_masked_pending", {24'd0, pending_l}, 32'hf0);
    exp_lo.push_back(4);
    exp_lo.push_back(5);
    exp_lo.push_back(6);
    exp_lo.push_back(7);
    sync();
    mask = 8'hff;
    waitCycles(7);
    checkOutput("s5_queue_drained", 32'(exp_lo.size()), 32'h0);
    checkOutput("s5_pending_end", {24'd0, pending_l}, 32'h0);

    $display("[TB] reset mid-operation");
    sync();
    out_ready = 1'b0;
    applyStimulus(8'h01, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checkOutput("s6_loaded_valid", {31'd0, out_valid_l}, 32'h1);
    applyStimulus(8'h81, 8'h00);
    @(negedge clk);
    checkOutput("s6_pre_pending", {24'd0, pending_l}, 32'h81);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("s6_rst_pending", {24'd0, pending_l}, 32'h0);
    checkOutput("s6_rst_dropped", {24'd0, dropped_l}, 32'h0);
    checkOutput("s6_rst_valid", {31'd0, out_valid_l}, 32'h0);
    checkOutput("s6_rst_onehot", {24'd0, out_onehot_l}, 32'h0);
    checkOutput("s6_rst_index", {29'd0, out_index_l}, 32'h0);
    sync();
    rst = 1'b0;
    out_ready = 1'b1;
    waitCycles(4);
    checkOutput("s6_idle_valid", {31'd0, out_valid_l}, 32'h0);
    checkOutput("s6_idle_pending", {24'd0, pending_l}, 32'h0);
    exp_lo.push_back(3);
    applyStimulus(8'h08, 8'h00);
    waitCycles(4);
    checkOutput("s6_queue_drained", 32'(exp_lo.size()), 32'h0);

    checkOutput("final_lo_queue", 32'(exp_lo.size()), 32'h0);
    checkOutput("final_hi_queue", 32'(exp_hi.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_event_server.md
# onehot_event_server

Collects single-cycle event pulses into sticky pending bits and serves them one at a time, lowest-index first by default, as a binary index on a valid/ready output. It is the consumer side of one-hot event/request vectors, such as IRQ lines or DMA channel requests. It sits between those event sources and a single sequential handler, for example an interrupt controller front end or a channel scheduler.

## Interface

- `W_INPUT`, default 8: number of event lines, at least 1.
- `HIGHEST_WINS`, default 0: if 1, the most-significant eligible bit is served first; otherwise the least-significant.
- `W_INDEX`, derived localparam: `W_INPUT > 1 ? $clog2(W_INPUT) : 1`.

- `clk`  in  1  sole clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_pulse`  in  W_INPUT  event strobes; each set bit marks that line pending.
- `mask`  in  W_INPUT  1 = line eligible for service; 0 = held pending but not served.
- `pending`  out  W_INPUT  registered sticky pending vector.
- `dropped`  out  W_INPUT  registered one-cycle pulse: an event arrived on an already-pending line.
- `out_valid`  out  1  output stage holds a served event.
- `out_ready`  in  1  consumer accepts the output this cycle.
- `out_index`  out  W_INDEX  binary index of the served line.
- `out_onehot`  out  W_INPUT  one-hot form of `out_index`; zero when `!out_valid`.

## Operation

- **Eligible set:** `elig = pending & mask`. The priority pick `sel` is the one-hot lowest (or highest, per `HIGHEST_WINS`) set bit of `elig`.
- **Load condition:** `load = |elig && (!out_valid || out_ready)`. When `load` is true:
  - the output stage captures `sel` (`out_onehot`) and its encoding (`out_index`);
  - `out_valid` goes to 1;
  - `take = sel`.
  - Otherwise `take = 0`.
- **Drain:** if `out_valid && out_ready && !|elig`, then `out_valid` goes to 0 and `out_onehot` to 0. `out_index` holds its last value (don't-care).
- **Pending update:** `pending_next = (pending & ~take) | in_pulse`. Set wins over clear: a pulse on the line being taken leaves it pending for a later service.
- **Drop detection:** `dropped_next = in_pulse & pending & ~take`. A pulse on a line currently sitting in the output stage, but no longer pending, is not a drop.
- **Output stability:** the output stage is stable while `out_valid && !out_ready`. Changes to `mask` or `pending` do not alter a presented output.
- **Masking:** a line masked after it was loaded is still delivered. Masked pending lines accumulate and are served after unmask, in priority order.
- **Reset:** `pending`, `dropped`, `out_valid`, `out_onehot` and `out_index` all go to 0 immediately. An in-flight output is discarded; events pulsed during reset are lost.

## Timing

- **Latency:** pulse sampled at edge N gives `pending` set after N. With the output stage free and the line unmasked, `out_valid` with that index is high after edge N+1. Pulse to `out_valid` is 2 cycles.
- **Throughput:** one event per cycle with `out_ready` held high. Back-to-back handshakes reload in the same cycle with no bubble.
- **Backpressure:** no combinational path from `out_ready` to `out_valid`, `out_index` or `out_onehot`. `out_ready` affects only next-state logic.
- `pending` and `dropped` are pure register outputs.

## Structure

- Put the `clog2` helper in the shared common header and use it for `W_INDEX`.
- Instantiate one `onehot_priority` sub-module (`W_INPUT`, `HIGHEST_WINS` passed through) to compute `sel` from `elig`.
- Do the one-hot-to-binary encode as an OR-reduction loop in this module. `sel` is guaranteed one-hot, so no priority encoding is needed.

## Test plan

All scenarios use `W_INPUT=8`.

1. **Basic ordering:** `HIGHEST_WINS=0`, `mask=8'hff`, `out_ready=1`, `in_pulse=8'b0010_1100` for one cycle → indices 2, 3, 5 on consecutive cycles starting 2 cycles later. `pending` ends at 0; no `dropped`.
2. **Highest wins:** `HIGHEST_WINS=1`, same stimulus → indices 5, 3, 2.
3. **Backpressure stability:** `out_ready=0`, pulse lines 1 and 6 → `out_index=1` held stable for 10 cycles, even while pulsing line 0. On raising `out_ready`, the sequence continues 0, 6.
4. **Drop and set-wins:**
   - Pulse line 4 twice while masked → `dropped[4]` pulses once, one cycle after the second pulse.
   - With line 4 unmasked, pulse it on the exact load cycle → it is served, remains pending, and is served again next.
5. **Masking:**
   - `mask=8'h0f`, pulse `8'hf0` → no `out_valid`, `pending=8'hf0`.
   - Set `mask=8'hff` → indices 4, 5, 6, 7.
6. **Reset mid-operation:** assert `rst` asynchronously while `out_valid=1` and `pending=8'h81` → all outputs zero before the next clock edge. After release, nothing is served until new pulses arrive.
